// File: rtl/ntt_coef_store_pkg.sv
// Shared definitions for the NTT twiddle-coefficient store: loader state
// encoding, default geometry and the even-parity helper.
package ntt_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_DEPTH  = 32;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W  = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Even parity bit: makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ntt_coef_store_if.sv
// Load stream and read-lane bundle of ntt_coef_store.
// Optional feature macro: NTT_COEF_STORE_PARITY_EN adds the rd_err lanes.
interface ntt_coef_store_if
  import ntt_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RD_PORTS = 2,
  parameter int ADDR_W   = $clog2(DEPTH)
) ();

  logic                         load_start;
  logic                         load_valid;
  logic [DATA_W-1:0]            load_data;
  logic                         load_ready;
  logic                         loaded;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;
  logic [RD_PORTS-1:0]          rd_valid;
`ifdef NTT_COEF_STORE_PARITY_EN
  logic [RD_PORTS-1:0]          rd_err;

  modport master (
    output load_start, load_valid, load_data, rd_en, rd_addr,
    input  load_ready, loaded, rd_data, rd_valid, rd_err
  );
  modport slave (
    input  load_start, load_valid, load_data, rd_en, rd_addr,
    output load_ready, loaded, rd_data, rd_valid, rd_err
  );
`else
  modport master (
    output load_start, load_valid, load_data, rd_en, rd_addr,
    input  load_ready, loaded, rd_data, rd_valid
  );
  modport slave (
    input  load_start, load_valid, load_data, rd_en, rd_addr,
    output load_ready, loaded, rd_data, rd_valid
  );
`endif

endinterface

// File: rtl/ntt_coef_store_rdport.sv
// One registered read lane of the coefficient store: range check, write
// bypass, output register and (optionally) parity check.
// Optional feature macro: NTT_COEF_STORE_PARITY_EN.
module ntt_coef_rdport
  import ntt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ENT_W  = DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic [DEPTH-1:0][ENT_W-1:0]  i_mem,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
`ifdef NTT_COEF_STORE_PARITY_EN
  output logic                         o_rd_err,
`endif
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_valid
);

  logic              w_in_range;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_idx;
  logic [ENT_W-1:0]  w_entry;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_err_nxt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_err;

  // Compare one bit wider so DEPTH == 2**ADDR_W does not truncate to zero.
  assign w_in_range = ({1'b0, i_rd_addr} < (ADDR_W+1)'(DEPTH));
  // Out-of-range addresses index entry 0; the result is discarded below.
  assign w_idx      = w_in_range ? i_rd_addr : '0;
  assign w_entry    = i_mem[w_idx];
  // The write pointer is always in range, so a match implies a valid address.
  assign w_bypass   = i_wr_en && (i_rd_addr == i_wr_addr);

  // Select the word this lane will register: zero, forwarded beat or entry.
  always_comb begin
    w_data_nxt = '0;
    w_err_nxt  = 1'b0;
    if (!w_in_range) begin
      w_data_nxt = '0;
      w_err_nxt  = 1'b1;
    end else if (w_bypass) begin
      w_data_nxt = i_wr_data;
      w_err_nxt  = 1'b0;
    end else begin
      w_data_nxt = w_entry[DATA_W-1:0];
`ifdef NTT_COEF_STORE_PARITY_EN
      w_err_nxt  = (even_parity(PAR_MAX_W'(w_entry[DATA_W-1:0])) != w_entry[ENT_W-1]);
`else
      w_err_nxt  = 1'b0;
`endif
    end
  end

  // Output register: data/err update only on a request, valid follows rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_data_nxt;
        r_rd_err  <= w_err_nxt;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
`ifdef NTT_COEF_STORE_PARITY_EN
  assign o_rd_err   = r_rd_err;
`else
  // Without parity the error path is inert; keep the bits consumed.
  logic w_unused_err;
  assign w_unused_err = r_rd_err ^ w_err_nxt;
`endif

endmodule

// File: rtl/ntt_coef_store.sv
// Twiddle-coefficient store: streamed loader with auto-incrementing write
// pointer feeding RD_PORTS independent registered read lanes with bypass.
// Optional feature macro: NTT_COEF_STORE_PARITY_EN stores an even-parity bit
// per entry and reports per-lane read errors.
module ntt_coef_store
  import ntt_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RD_PORTS = 2,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  ntt_coef_store_if.slave  bus
);

`ifdef NTT_COEF_STORE_PARITY_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  loader_state_e                    r_state;
  loader_state_e                    w_state_nxt;
  logic [ADDR_W-1:0]                r_wptr;
  logic [ADDR_W-1:0]                w_wptr_nxt;
  logic                             w_accept;
  logic [ENT_W-1:0]                 w_wr_entry;
  logic [DEPTH-1:0][ENT_W-1:0]      r_mem;
  logic [RD_PORTS-1:0][DATA_W-1:0]  w_rd_data;
  logic [RD_PORTS-1:0]              w_rd_valid;

  assign w_accept       = bus.load_valid && (r_state == LOAD);
  assign bus.load_ready = (r_state == LOAD);
  assign bus.loaded     = (r_state == DONE);

`ifdef NTT_COEF_STORE_PARITY_EN
  assign w_wr_entry = {even_parity(PAR_MAX_W'(bus.load_data)), bus.load_data};
`else
  assign w_wr_entry = bus.load_data;
`endif

  // Loader state and write pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
    end
  end

  // Loader next state: load_start always (re)starts at entry 0; the last
  // accepted beat parks the pointer at DEPTH-1 and moves to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    case (r_state)
      IDLE: begin
        if (bus.load_start) begin
          w_state_nxt = LOAD;
          w_wptr_nxt  = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          w_state_nxt = LOAD;
          w_wptr_nxt  = '0;
        end else if (w_accept) begin
          if (r_wptr == ADDR_W'(DEPTH - 1)) begin
            w_state_nxt = DONE;
          end else begin
            w_wptr_nxt  = r_wptr + ADDR_W'(1);
          end
        end else begin
          w_state_nxt = LOAD;
        end
      end
      DONE: begin
        if (bus.load_start) begin
          w_state_nxt = LOAD;
          w_wptr_nxt  = '0;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wptr_nxt  = '0;
      end
    endcase
  end

  // Coefficient array: cleared by reset, one entry written per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (w_accept) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

`ifdef NTT_COEF_STORE_PARITY_EN
  logic [RD_PORTS-1:0] w_rd_err;
  assign bus.rd_err = w_rd_err;
`endif

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_lane
    ntt_coef_rdport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .ENT_W  (ENT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_rd_en    (bus.rd_en[k]),
      .i_rd_addr  (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .i_mem      (r_mem),
      .i_wr_en    (w_accept),
      .i_wr_addr  (r_wptr),
      .i_wr_data  (bus.load_data),
`ifdef NTT_COEF_STORE_PARITY_EN
      .o_rd_err   (w_rd_err[k]),
`endif
      .o_rd_data  (w_rd_data[k]),
      .o_rd_valid (w_rd_valid[k])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_valid = w_rd_valid;

endmodule

// File: tb/tb_ntt_coef_store.sv
// Self-checking bench for ntt_coef_store: table-driven read vectors plus
// hand-written load / bypass / restart / reset sequences, per-lane scoreboard.
// Optional feature macro: NTT_COEF_STORE_PARITY_EN enables the parity checks.
module tb_ntt_coef_store;
  import ntt_pkg::*;

  localparam int DW  = 96;
  localparam int DP  = 32;
  localparam int RP  = 2;
  localparam int AW  = 5;
  localparam int DP2 = 40;
  localparam int AW2 = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_coef_store_if #(.DATA_W(DW), .DEPTH(DP),  .RD_PORTS(RP), .ADDR_W(AW))  u_if  ();
  ntt_coef_store_if #(.DATA_W(DW), .DEPTH(DP2), .RD_PORTS(RP), .ADDR_W(AW2)) u_if2 ();

  ntt_coef_store #(.DATA_W(DW), .DEPTH(DP),  .RD_PORTS(RP), .ADDR_W(AW))  dut  (.clk(clk), .rst(rst), .bus(u_if));
  ntt_coef_store #(.DATA_W(DW), .DEPTH(DP2), .RD_PORTS(RP), .ADDR_W(AW2)) dut2 (.clk(clk), .rst(rst), .bus(u_if2));

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  typedef struct {
    logic [1:0]    en;
    int            a0;
    int            a1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] m_mem [DP];
  logic [DW-1:0] last_exp [RP];
  exp_t          sb_q [RP][$];
  vec_t          vt [7];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every lane against what was queued for the cycle just clocked.
  task automatic check_reads(input logic [RP-1:0] en);
    exp_t e;
    for (int k = 0; k < RP; k++) begin
      if (en[k]) begin
        if (sb_q[k].size() == 0) begin
          check("sb_underflow", DW'(1), DW'(0));
        end else begin
          e = sb_q[k].pop_front();
          check($sformatf("rd_valid[%0d]", k), DW'(u_if.rd_valid[k]), DW'(1));
          check($sformatf("rd_data[%0d]", k), u_if.rd_data[k*DW +: DW], e.data);
`ifdef NTT_COEF_STORE_PARITY_EN
          check($sformatf("rd_err[%0d]", k), DW'(u_if.rd_err[k]), DW'(e.err));
`endif
          last_exp[k] = e.data;
        end
      end else begin
        check($sformatf("rd_idle_valid[%0d]", k), DW'(u_if.rd_valid[k]), DW'(0));
        check($sformatf("rd_hold[%0d]", k), u_if.rd_data[k*DW +: DW], last_exp[k]);
      end
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then inputs idle.
  task automatic tick();
    logic [RP-1:0] en_s;
    en_s = u_if.rd_en;
    @(posedge clk);
    #1;
    check_reads(en_s);
    u_if.load_start  = 1'b0;
    u_if.load_valid  = 1'b0;
    u_if.rd_en       = '0;
    u_if2.load_start = 1'b0;
    u_if2.load_valid = 1'b0;
    u_if2.rd_en      = '0;
  endtask

  task automatic rd(input int lane, input int addr, input logic [DW-1:0] exp, input logic err);
    exp_t e;
    u_if.rd_en[lane] = 1'b1;
    u_if.rd_addr[lane*AW +: AW] = AW'(addr);
    e.data = exp;
    e.err  = err;
    sb_q[lane].push_back(e);
  endtask

  task automatic beat(input int idx, input logic [DW-1:0] data);
    u_if.load_valid = 1'b1;
    u_if.load_data  = data;
    m_mem[idx]      = data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    for (int k = 0; k < RP; k++) begin
      last_exp[k] = '0;
      sb_q[k].delete();
    end
  endtask

  task automatic full_load(input int mul);
    u_if.load_start = 1'b1;
    tick();
    for (int i = 0; i < DP; i++) begin
      beat(i, DW'(i * mul));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    u_if.load_start  = 1'b0;
    u_if.load_valid  = 1'b0;
    u_if.load_data   = '0;
    u_if.rd_en       = '0;
    u_if.rd_addr     = '0;
    u_if2.load_start = 1'b0;
    u_if2.load_valid = 1'b0;
    u_if2.load_data  = '0;
    u_if2.rd_en      = '0;
    u_if2.rd_addr    = '0;
    model_reset();

    // Read vectors applied after a load with data = idx*3.
    vt[0] = '{en: 2'b11, a0: 0,  a1: 31, e0: DW'(0),  e1: DW'(93)};
    vt[1] = '{en: 2'b01, a0: 5,  a1: 0,  e0: DW'(15), e1: DW'(0)};
    vt[2] = '{en: 2'b10, a0: 0,  a1: 30, e0: DW'(0),  e1: DW'(90)};
    vt[3] = '{en: 2'b11, a0: 7,  a1: 7,  e0: DW'(21), e1: DW'(21)};
    vt[4] = '{en: 2'b00, a0: 9,  a1: 9,  e0: DW'(0),  e1: DW'(0)};
    vt[5] = '{en: 2'b11, a0: 16, a1: 1,  e0: DW'(48), e1: DW'(3)};
    vt[6] = '{en: 2'b11, a0: 31, a1: 0,  e0: DW'(93), e1: DW'(0)};

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("rst_load_ready", DW'(u_if.load_ready), DW'(0));
    check("rst_loaded", DW'(u_if.loaded), DW'(0));
    check("rst_rd_valid", DW'(u_if.rd_valid), DW'(0));
    check("rst_rd_data", u_if.rd_data[DW-1:0], DW'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // First full load: ready exactly while the 32 beats are sent.
    check("idle_ready", DW'(u_if.load_ready), DW'(0));
    u_if.load_start = 1'b1;
    tick();
    for (int i = 0; i < DP; i++) begin
      check("load_ready_hi", DW'(u_if.load_ready), DW'(1));
      check("loaded_lo", DW'(u_if.loaded), DW'(0));
      beat(i, DW'(i * 3));
      tick();
    end
    check("loaded_after_last", DW'(u_if.loaded), DW'(1));
    check("ready_after_last", DW'(u_if.load_ready), DW'(0));
    rd(0, 5, DW'(15), 1'b0);
    tick();

    // Table-driven read vectors.
    for (int v = 0; v < 7; v++) begin
      if (vt[v].en[0]) rd(0, vt[v].a0, vt[v].e0, 1'b0);
      if (vt[v].en[1]) rd(1, vt[v].a1, vt[v].e1, 1'b0);
      tick();
    end

    // Reload with both lanes reading entry 7 while it is being written.
    u_if.load_start = 1'b1;
    tick();
    check("loaded_falls", DW'(u_if.loaded), DW'(0));
    for (int i = 0; i < DP; i++) begin
      beat(i, (i == 7) ? DW'(12'hABC) : DW'(i * 3));
      if (i == 7) begin
        rd(0, 7, DW'(12'hABC), 1'b0);
        rd(1, 7, DW'(12'hABC), 1'b0);
      end
      tick();
    end
    rd(1, 7, DW'(12'hABC), 1'b0);
    tick();

    // Restart after 10 beats; loaded only after the second full pass.
    u_if.load_start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      beat(i, DW'(i + 500));
      tick();
    end
    u_if.load_start = 1'b1;
    tick();
    for (int i = 0; i < DP; i++) begin
      check("restart_ready", DW'(u_if.load_ready), DW'(1));
      check("restart_loaded_lo", DW'(u_if.loaded), DW'(0));
      beat(i, DW'(i + 700));
      tick();
    end
    check("restart_loaded", DW'(u_if.loaded), DW'(1));
    rd(0, 3, DW'(703), 1'b0);
    rd(1, 12, DW'(712), 1'b0);
    tick();

    // Reset asserted at beat 20 of a load.
    u_if.load_start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      beat(i, DW'(i + 900));
      if (i == 19) rd(0, 19, DW'(919), 1'b0);
      tick();
    end
    beat(20, DW'(920));
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_ready", DW'(u_if.load_ready), DW'(0));
    check("mid_rst_loaded", DW'(u_if.loaded), DW'(0));
    check("mid_rst_valid", DW'(u_if.rd_valid), DW'(0));
    check("mid_rst_data0", u_if.rd_data[DW-1:0], DW'(0));
    u_if.load_valid = 1'b0;
    tick();
    rst = 1'b0;
    rd(0, 0, DW'(0), 1'b0);
    rd(1, 5, DW'(0), 1'b0);
    tick();
    check("post_rst_loaded", DW'(u_if.loaded), DW'(0));

    // Second configuration (DEPTH = 40): out-of-range read returns zero.
    u_if2.load_start = 1'b1;
    tick();
    for (int i = 0; i < DP2; i++) begin
      u_if2.load_valid = 1'b1;
      u_if2.load_data  = DW'(i + 100);
      tick();
    end
    check("cfg2_loaded", DW'(u_if2.loaded), DW'(1));
    u_if2.rd_en   = 2'b11;
    u_if2.rd_addr = {AW2'(39), AW2'(40)};
    tick();
    check("cfg2_oor_data", u_if2.rd_data[DW-1:0], DW'(0));
    check("cfg2_oor_valid", DW'(u_if2.rd_valid[0]), DW'(1));
    check("cfg2_last_data", u_if2.rd_data[DW +: DW], DW'(139));
    check("cfg2_last_valid", DW'(u_if2.rd_valid[1]), DW'(1));
`ifdef NTT_COEF_STORE_PARITY_EN
    check("cfg2_oor_err", DW'(u_if2.rd_err[0]), DW'(1));
    check("cfg2_last_err", DW'(u_if2.rd_err[1]), DW'(0));
`endif

`ifdef NTT_COEF_STORE_PARITY_EN
    // Parity: corrupt the stored parity bit of entry 2.
    begin
      logic [DP-1:0][DW:0] corr;
      full_load(3);
      rd(0, 3, DW'(9), 1'b0);
      rd(1, 2, DW'(6), 1'b0);
      tick();
      for (int i = 0; i < DP; i++) corr[i] = {^m_mem[i], m_mem[i]};
      corr[2][DW] = ~corr[2][DW];
      force dut.r_mem = corr;
      rd(0, 3, DW'(9), 1'b0);
      rd(1, 2, DW'(6), 1'b1);
      tick();
      release dut.r_mem;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
